// File: rtl/combo_lock_ctrl.sv
// rtl/combo_lock_ctrl.sv - safe combination-lock controller with programmable code and timed lockout
module combo_lock_ctrl #(
    parameter int NUM_DIGITS     = 3,
    parameter int DIGIT_W        = 6,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 1024,
    parameter logic [NUM_DIGITS*DIGIT_W-1:0] RESET_CODE = {6'd3, 6'd2, 6'd1},
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
    localparam int FAIL_W = $clog2(MAX_FAILS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               open,
    input  logic               dirch,
    input  logic [DIGIT_W-1:0] dial,
    input  logic               doorCls,
    input  logic               lock,
    input  logic               prog_we,
    input  logic [IDX_W-1:0]   prog_idx,
    input  logic [DIGIT_W-1:0] prog_val,
    output logic               countEn,
    output logic               clrCount,
    output logic               actuateLock,
    output logic               blank,
    output logic               safeOpen,
    output logic [IDX_W-1:0]   sel,
    output logic               lockedOut,
    output logic [FAIL_W-1:0]  fail_cnt
);

    localparam int TMR_W = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [IDX_W:0]    DIGITS_LIM = (IDX_W + 1)'(NUM_DIGITS);
    localparam logic [FAIL_W-1:0] MAX_F      = FAIL_W'(MAX_FAILS);
    localparam logic [TMR_W-1:0]  TMR_LOAD   = TMR_W'(LOCKOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        LOCKED, ENTRY, BAD, LOCKOUT, OPEN_PULSE, UNLOCKED, RELOCK
    } state_t;

    state_t              state, state_d;
    logic [IDX_W-1:0]    idx, idx_d;
    logic [FAIL_W-1:0]   fail, fail_d, fail_inc;
    logic [TMR_W-1:0]    timer, timer_d;
    logic [DIGIT_W-1:0]  code [NUM_DIGITS];
    logic                digit_ok;
    logic                accept;
    logic                code_we;

    always_comb begin
        state_d  = state;
        idx_d    = idx;
        fail_d   = fail;
        timer_d  = timer;
        accept   = 1'b0;
        code_we  = 1'b0;
        digit_ok = (dial == code[idx]);
        fail_inc = (fail == MAX_F) ? fail : fail + 1'b1;
        case (state)
            LOCKED: begin
                if (open) begin
                    state_d = ENTRY;
                    idx_d   = '0;
                end
            end
            ENTRY: begin
                // Final digit is confirmed by open; a matching dirch there is a no-op
                if (idx == LAST_IDX) begin
                    if (open)
                        state_d = digit_ok ? OPEN_PULSE : BAD;
                    else if (dirch && !digit_ok)
                        state_d = BAD;
                end else if (dirch) begin
                    if (digit_ok) begin
                        idx_d  = idx + 1'b1;
                        accept = 1'b1;
                    end else begin
                        state_d = BAD;
                    end
                end
            end
            BAD: begin
                fail_d = fail_inc;
                if (fail_inc == MAX_F) begin
                    state_d = LOCKOUT;
                    timer_d = TMR_LOAD;
                end else begin
                    state_d = LOCKED;
                end
            end
            LOCKOUT: begin
                if (timer == '0) begin
                    state_d = LOCKED;
                    fail_d  = '0;
                end else begin
                    timer_d = timer - 1'b1;
                end
            end
            OPEN_PULSE: begin
                fail_d  = '0;
                state_d = UNLOCKED;
            end
            UNLOCKED: begin
                code_we = prog_we && ({1'b0, prog_idx} < DIGITS_LIM);
                if (lock && doorCls)
                    state_d = RELOCK;
            end
            RELOCK:  state_d = LOCKED;
            default: state_d = LOCKED;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LOCKED;
            idx   <= '0;
            fail  <= '0;
            timer <= '0;
            for (int i = 0; i < NUM_DIGITS; i++)
                code[i] <= RESET_CODE[i*DIGIT_W +: DIGIT_W];
        end else begin
            state <= state_d;
            idx   <= idx_d;
            fail  <= fail_d;
            timer <= timer_d;
            if (code_we)
                code[prog_idx] <= prog_val;
        end
    end

    // Outputs lag the state by one cycle; clrCount also marks the cycle after an accepted digit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            countEn     <= 1'b0;
            clrCount    <= 1'b1;
            actuateLock <= 1'b0;
            blank       <= 1'b1;
            safeOpen    <= 1'b0;
            lockedOut   <= 1'b0;
            sel         <= '0;
        end else begin
            countEn     <= (state == ENTRY);
            clrCount    <= (state == LOCKED) || (state == UNLOCKED) || (state == LOCKOUT) || accept;
            actuateLock <= (state == OPEN_PULSE) || (state == RELOCK);
            blank       <= (state != ENTRY);
            safeOpen    <= (state == UNLOCKED);
            lockedOut   <= (state == LOCKOUT);
            sel         <= (state == ENTRY) ? idx : '0;
        end
    end

    assign fail_cnt = fail;

endmodule

// File: tb/tb_combo_lock_ctrl.sv
// tb/tb_combo_lock_ctrl.sv - self-checking bench for combo_lock_ctrl with a combination-level model
module tb_combo_lock_ctrl;

    localparam int L = 16;

    logic       clk = 1'b0;
    logic       rst, open, dirch, doorCls, lock, prog_we;
    logic [5:0] dial, prog_val;
    logic [1:0] prog_idx;
    logic       countEn, clrCount, actuateLock, blank, safeOpen, lockedOut;
    logic [1:0] sel, fail_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [5:0] m_code [3];
    int         m_fails;

    combo_lock_ctrl #(.LOCKOUT_CYCLES(L)) dut (
        .clk(clk), .rst(rst), .open(open), .dirch(dirch), .dial(dial),
        .doorCls(doorCls), .lock(lock), .prog_we(prog_we), .prog_idx(prog_idx),
        .prog_val(prog_val), .countEn(countEn), .clrCount(clrCount),
        .actuateLock(actuateLock), .blank(blank), .safeOpen(safeOpen), .sel(sel),
        .lockedOut(lockedOut), .fail_cnt(fail_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_open(input logic [5:0] v);
        dial = v; open = 1'b1; tick(); open = 1'b0;
    endtask

    task automatic pulse_dirch(input logic [5:0] v);
        dial = v; dirch = 1'b1; tick(); dirch = 1'b0;
    endtask

    // Drives one attempt, stopping at the first digit the model says is wrong
    task automatic drive_attempt(input logic [5:0] d0, input logic [5:0] d1, input logic [5:0] d2, output bit ok);
        ok = 1'b0;
        pulse_open(6'd0);
        pulse_dirch(d0);
        if (d0 == m_code[0]) begin
            pulse_dirch(d1);
            if (d1 == m_code[1]) begin
                pulse_open(d2);
                ok = (d2 == m_code[2]);
            end
        end
        if (ok) m_fails = 0;
        else if (m_fails < 3) m_fails++;
    endtask

    task automatic do_relock;
        lock = 1'b1; doorCls = 1'b1; tick();
        lock = 1'b0; doorCls = 1'b0; tick(); tick();
    endtask

    task automatic model_reset;
        m_code[0] = 6'd1; m_code[1] = 6'd2; m_code[2] = 6'd3;
        m_fails = 0;
    endtask

    task automatic test_reset;
        rst = 1'b1; open = 0; dirch = 0; doorCls = 0; lock = 0; prog_we = 0;
        dial = '0; prog_val = '0; prog_idx = '0;
        model_reset();
        tick(); tick();
        tests_run++; if (countEn !== 1'b0) begin tests_failed++; $display("FAIL reset_countEn: got %b expected 0", countEn); end
        tests_run++; if (clrCount !== 1'b1) begin tests_failed++; $display("FAIL reset_clrCount: got %b expected 1", clrCount); end
        tests_run++; if (actuateLock !== 1'b0) begin tests_failed++; $display("FAIL reset_actuateLock: got %b expected 0", actuateLock); end
        tests_run++; if (blank !== 1'b1) begin tests_failed++; $display("FAIL reset_blank: got %b expected 1", blank); end
        tests_run++; if (safeOpen !== 1'b0) begin tests_failed++; $display("FAIL reset_safeOpen: got %b expected 0", safeOpen); end
        tests_run++; if (lockedOut !== 1'b0) begin tests_failed++; $display("FAIL reset_lockedOut: got %b expected 0", lockedOut); end
        tests_run++; if (sel !== 2'd0) begin tests_failed++; $display("FAIL reset_sel: got %0d expected 0", sel); end
        tests_run++; if (fail_cnt !== 2'd0) begin tests_failed++; $display("FAIL reset_fail_cnt: got %0d expected 0", fail_cnt); end
        rst = 1'b0;
        tick();
        tests_run++; if (clrCount !== 1'b1 || blank !== 1'b1) begin tests_failed++; $display("FAIL reset_idle: got clr=%b blank=%b expected 1 1", clrCount, blank); end
    endtask

    task automatic test_correct_code;
        pulse_open(6'd0);
        pulse_dirch(6'd1);
        tests_run++; if (countEn !== 1'b1 || blank !== 1'b0) begin tests_failed++; $display("FAIL entry_display: got countEn=%b blank=%b expected 1 0", countEn, blank); end
        tests_run++; if (sel !== 2'd0 || clrCount !== 1'b1) begin tests_failed++; $display("FAIL entry_digit0: got sel=%0d clr=%b expected 0 1", sel, clrCount); end
        pulse_dirch(6'd2);
        tests_run++; if (sel !== 2'd1 || clrCount !== 1'b1) begin tests_failed++; $display("FAIL entry_digit1: got sel=%0d clr=%b expected 1 1", sel, clrCount); end
        pulse_open(6'd3);
        tests_run++; if (sel !== 2'd2 || clrCount !== 1'b0) begin tests_failed++; $display("FAIL entry_digit2: got sel=%0d clr=%b expected 2 0", sel, clrCount); end
        tick();
        tests_run++; if (actuateLock !== 1'b1 || safeOpen !== 1'b0) begin tests_failed++; $display("FAIL open_pulse: got act=%b open=%b expected 1 0", actuateLock, safeOpen); end
        tick();
        tests_run++; if (actuateLock !== 1'b0 || safeOpen !== 1'b1 || fail_cnt !== 2'd0) begin tests_failed++; $display("FAIL unlocked: got act=%b open=%b fails=%0d expected 0 1 0", actuateLock, safeOpen, fail_cnt); end
        do_relock();
    endtask

    task automatic test_wrong_digit;
        bit ok;
        drive_attempt(6'd1, 6'd5, 6'd3, ok);
        tick(); tick();
        tests_run++; if (fail_cnt !== 2'(m_fails)) begin tests_failed++; $display("FAIL wrong_fail_cnt: got %0d expected %0d", fail_cnt, m_fails); end
        tests_run++; if (blank !== 1'b1 || safeOpen !== 1'b0 || lockedOut !== 1'b0) begin tests_failed++; $display("FAIL wrong_outputs: got blank=%b open=%b lo=%b expected 1 0 0", blank, safeOpen, lockedOut); end
    endtask

    task automatic test_lockout;
        bit ok;
        int cnt;
        logic [5:0] d [3];
        int p;
        while (m_fails < 3) begin
            d = m_code;
            p = $urandom_range(0, 2);
            d[p] = d[p] ^ 6'($urandom_range(1, 63));
            drive_attempt(d[0], d[1], d[2], ok);
            tick(); tick();
            tests_run++; if (fail_cnt !== 2'(m_fails) || lockedOut !== (m_fails == 3)) begin tests_failed++; $display("FAIL lockout_build: got fails=%0d lo=%b expected %0d %b", fail_cnt, lockedOut, m_fails, m_fails == 3); end
        end
        cnt = 0;
        while (lockedOut === 1'b1 && cnt < 4 * L) begin
            cnt++;
            open = (cnt == 3);
            dial = 6'd0;
            tick();
        end
        open = 1'b0;
        m_fails = 0;
        tests_run++; if (cnt != L) begin tests_failed++; $display("FAIL lockout_len: got %0d expected %0d", cnt, L); end
        tests_run++; if (fail_cnt !== 2'd0 || blank !== 1'b1) begin tests_failed++; $display("FAIL lockout_exit: got fails=%0d blank=%b expected 0 1", fail_cnt, blank); end
        drive_attempt(m_code[0], m_code[1], m_code[2], ok);
        tick(); tick();
        tests_run++; if (safeOpen !== 1'b1) begin tests_failed++; $display("FAIL lockout_reopen: got %b expected 1", safeOpen); end
        do_relock();
    endtask

    task automatic test_reprogram;
        bit ok;
        prog_we = 1'b1; prog_idx = 2'd0; prog_val = 6'd33; tick(); prog_we = 1'b0;
        drive_attempt(6'd1, 6'd2, 6'd3, ok);
        tick(); tick();
        tests_run++; if (safeOpen !== 1'b1) begin tests_failed++; $display("FAIL prog_locked_ignored: got safeOpen=%b expected 1", safeOpen); end
        prog_we = 1'b1;
        prog_idx = 2'd0; prog_val = 6'd9;  tick();
        prog_idx = 2'd1; prog_val = 6'd8;  tick();
        prog_idx = 2'd3; prog_val = 6'd55; tick();
        prog_idx = 2'd2; prog_val = 6'd7; lock = 1'b1; doorCls = 1'b1; tick();
        prog_we = 1'b0; lock = 1'b0; doorCls = 1'b0;
        m_code[0] = 6'd9; m_code[1] = 6'd8; m_code[2] = 6'd7;
        tick();
        tests_run++; if (actuateLock !== 1'b1) begin tests_failed++; $display("FAIL prog_relock_pulse: got %b expected 1", actuateLock); end
        tick();
        tests_run++; if (actuateLock !== 1'b0 || safeOpen !== 1'b0 || clrCount !== 1'b1) begin tests_failed++; $display("FAIL prog_locked: got act=%b open=%b clr=%b expected 0 0 1", actuateLock, safeOpen, clrCount); end
        drive_attempt(6'd1, 6'd2, 6'd3, ok);
        tick(); tick();
        tests_run++; if (fail_cnt !== 2'(m_fails) || safeOpen !== 1'b0) begin tests_failed++; $display("FAIL prog_old_code: got fails=%0d open=%b expected %0d 0", fail_cnt, safeOpen, m_fails); end
        drive_attempt(6'd9, 6'd8, 6'd7, ok);
        tick(); tick();
        tests_run++; if (safeOpen !== 1'b1 || fail_cnt !== 2'd0) begin tests_failed++; $display("FAIL prog_new_code: got open=%b fails=%0d expected 1 0", safeOpen, fail_cnt); end
    endtask

    task automatic test_relock_guard;
        lock = 1'b1; doorCls = 1'b0;
        repeat (4) tick();
        tests_run++; if (safeOpen !== 1'b1 || actuateLock !== 1'b0) begin tests_failed++; $display("FAIL guard_hold: got open=%b act=%b expected 1 0", safeOpen, actuateLock); end
        doorCls = 1'b1; tick();
        lock = 1'b0; doorCls = 1'b0; tick();
        tests_run++; if (actuateLock !== 1'b1) begin tests_failed++; $display("FAIL guard_pulse: got %b expected 1", actuateLock); end
        tick();
        tests_run++; if (actuateLock !== 1'b0 || safeOpen !== 1'b0 || clrCount !== 1'b1) begin tests_failed++; $display("FAIL guard_locked: got act=%b open=%b clr=%b expected 0 0 1", actuateLock, safeOpen, clrCount); end
    endtask

    task automatic test_reset_mid_entry;
        bit ok;
        pulse_open(6'd0);
        pulse_dirch(m_code[0]);
        pulse_dirch(m_code[1]);
        rst = 1'b1; #1;
        tests_run++; if (countEn !== 1'b0 || clrCount !== 1'b1 || blank !== 1'b1 || sel !== 2'd0) begin tests_failed++; $display("FAIL midrst_entry_outs: got en=%b clr=%b blank=%b sel=%0d expected 0 1 1 0", countEn, clrCount, blank, sel); end
        tests_run++; if (actuateLock !== 1'b0 || safeOpen !== 1'b0 || lockedOut !== 1'b0 || fail_cnt !== 2'd0) begin tests_failed++; $display("FAIL midrst_other_outs: got act=%b open=%b lo=%b fails=%0d expected 0 0 0 0", actuateLock, safeOpen, lockedOut, fail_cnt); end
        tick();
        rst = 1'b0;
        model_reset();
        tick();
        drive_attempt(6'd1, 6'd2, 6'd3, ok);
        tick(); tick();
        tests_run++; if (safeOpen !== 1'b1) begin tests_failed++; $display("FAIL midrst_code_restored: got %b expected 1", safeOpen); end
        do_relock();
    endtask

    task automatic test_random;
        bit ok;
        int cnt;
        int p;
        int n;
        logic [5:0] d [3];
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                prog_we = 1'b1; prog_idx = 2'($urandom_range(0, 3)); prog_val = 6'($urandom); tick(); prog_we = 1'b0;
            end
            d = m_code;
            if ($urandom_range(0, 1) == 1) begin
                p = $urandom_range(0, 2);
                d[p] = d[p] ^ 6'($urandom_range(1, 63));
            end
            drive_attempt(d[0], d[1], d[2], ok);
            tick(); tick();
            if (ok) begin
                tests_run++; if (safeOpen !== 1'b1 || fail_cnt !== 2'd0) begin tests_failed++; $display("FAIL rand_open it=%0d: got open=%b fails=%0d expected 1 0", it, safeOpen, fail_cnt); end
                n = $urandom_range(0, 3);
                for (int k = 0; k < n; k++) begin
                    prog_we = 1'b1; prog_idx = 2'($urandom_range(0, 3)); prog_val = 6'($urandom);
                    if (prog_idx < 2'd3) m_code[prog_idx] = prog_val;
                    tick();
                end
                prog_we = 1'b0;
                do_relock();
                tests_run++; if (safeOpen !== 1'b0 || clrCount !== 1'b1) begin tests_failed++; $display("FAIL rand_relock it=%0d: got open=%b clr=%b expected 0 1", it, safeOpen, clrCount); end
            end else if (m_fails == 3) begin
                cnt = 0;
                while (lockedOut === 1'b1 && cnt < 4 * L) begin
                    cnt++;
                    tick();
                end
                m_fails = 0;
                tests_run++; if (cnt != L || fail_cnt !== 2'd0) begin tests_failed++; $display("FAIL rand_lockout it=%0d: got len=%0d fails=%0d expected %0d 0", it, cnt, fail_cnt, L); end
            end else begin
                tests_run++; if (fail_cnt !== 2'(m_fails) || safeOpen !== 1'b0 || lockedOut !== 1'b0) begin tests_failed++; $display("FAIL rand_bad it=%0d: got fails=%0d open=%b lo=%b expected %0d 0 0", it, fail_cnt, safeOpen, lockedOut, m_fails); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_correct_code();
        test_wrong_digit();
        test_lockout();
        test_reprogram();
        test_relock_guard();
        test_reset_mid_entry();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
